// File: rtl/exc_pkg.sv
// exc_pkg: ExcCodes, Status bit indices and FSM state encoding shared by
// exc_ctrl and the CP0-side logic.
package exc_pkg;

    localparam logic [4:0] EXC_INT = 5'b00000;
    localparam logic [4:0] EXC_SYS = 5'b01000;
    localparam logic [4:0] EXC_BRK = 5'b01001;
    localparam logic [4:0] EXC_TEQ = 5'b01101;

    localparam int ST_IE  = 0;
    localparam int ST_SYS = 1;
    localparam int ST_BRK = 2;
    localparam int ST_TEQ = 3;
    localparam int ST_IM  = 8;

    typedef enum logic [1:0] {IDLE, EXC, RET, FLUSH} state_t;

endpackage

// File: rtl/int_pend.sv
// int_pend: rising-edge detect on ext_int, sticky pending latch, and
// lowest-index-first selection of an enabled pending line.
module int_pend (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ext_int,
    input  logic [3:0] mask,
    input  logic       take,
    output logic       req,
    output logic [3:0] pending
);

    logic [3:0] prev_q, prev_d, pend_q, pend_d, hit, sel;

    always_comb begin
        hit     = pend_q & mask;
        sel     = hit & (~hit + 4'd1);
        req     = |hit;
        prev_d  = ext_int;
        // an edge arriving while the line is being taken re-arms the bit
        pend_d  = (pend_q & ~(take ? sel : 4'b0)) | (ext_int & ~prev_q);
        pending = pend_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            pend_q <= '0;
        end else begin
            prev_q <= prev_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: prioritises decode exceptions, eret and external interrupts into
// one-cycle CP0 requests followed by a flush. Interrupts need EXC_EXT_INT_EN.
module exc_ctrl
    import exc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        syscall,
    input  logic        brk,
    input  logic        teq_hit,
    input  logic        eret_in,
    input  logic [31:0] pc,
    input  logic [31:0] status,
    input  logic [3:0]  ext_int,
    output logic        exception,
    output logic [4:0]  cause,
    output logic        eret,
    output logic [31:0] exc_pc,
    output logic        flush,
    output logic [3:0]  int_pending
);

    state_t      state_q, state_d;
    logic        exc_q, exc_d, eret_q, eret_d, flush_q, flush_d;
    logic [4:0]  cause_q, cause_d;
    logic [31:0] pc_q, pc_d;
    logic        sys_en, brk_en, teq_en, int_req, int_take;
    logic        unused_st;

    assign unused_st = ^{status[31:12], status[7:4]};

`ifdef EXC_EXT_INT_EN
    int_pend u_int_pend (
        .clk     (clk),
        .rst     (rst),
        .ext_int (ext_int),
        .mask    (status[ST_IM +: 4] & {4{status[ST_IE]}}),
        .take    (int_take),
        .req     (int_req),
        .pending (int_pending)
    );
`else
    logic unused_int;
    assign unused_int  = ^{ext_int, status[ST_IM +: 4], int_take};
    assign int_req     = 1'b0;
    assign int_pending = 4'b0;
`endif

    always_comb begin
        sys_en   = status[ST_IE] & status[ST_SYS] & syscall;
        brk_en   = status[ST_IE] & status[ST_BRK] & brk;
        teq_en   = status[ST_IE] & status[ST_TEQ] & teq_hit;
        int_take = 1'b0;
        state_d  = state_q;
        exc_d    = 1'b0;
        eret_d   = 1'b0;
        flush_d  = 1'b0;
        cause_d  = '0;
        pc_d     = '0;
        case (state_q)
            IDLE: begin
                if (sys_en | brk_en | teq_en) begin
                    state_d = EXC;
                    exc_d   = 1'b1;
                    flush_d = 1'b1;
                    cause_d = sys_en ? EXC_SYS : brk_en ? EXC_BRK : EXC_TEQ;
                    pc_d    = pc;
                end else if (eret_in) begin
                    state_d = RET;
                    eret_d  = 1'b1;
                    flush_d = 1'b1;
                end else if (int_req & ~syscall & ~brk & ~teq_hit) begin
                    int_take = 1'b1;
                    state_d  = EXC;
                    exc_d    = 1'b1;
                    flush_d  = 1'b1;
                    cause_d  = EXC_INT;
                    pc_d     = pc;
                end
            end
            EXC, RET: begin
                state_d = FLUSH;
                flush_d = 1'b1;
                cause_d = cause_q;
                pc_d    = pc_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            exc_q   <= 1'b0;
            eret_q  <= 1'b0;
            flush_q <= 1'b0;
            cause_q <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            exc_q   <= exc_d;
            eret_q  <= eret_d;
            flush_q <= flush_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
        end
    end

    assign exception = exc_q;
    assign eret      = eret_q;
    assign flush     = flush_q;
    assign cause     = cause_q;
    assign exc_pc    = pc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed vectors for exc_ctrl, checked every cycle against a
// sequence-level model plus literal expectations. Define EXC_EXT_INT_EN to
// exercise interrupts.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst, syscall, brk, teq_hit, eret_in;
    logic [31:0] pc, status;
    logic [3:0]  ext_int;
    logic        exception, eret, flush;
    logic [4:0]  cause;
    logic [31:0] exc_pc;
    logic [3:0]  int_pending;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    exc_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .syscall     (syscall),
        .brk         (brk),
        .teq_hit     (teq_hit),
        .eret_in     (eret_in),
        .pc          (pc),
        .status      (status),
        .ext_int     (ext_int),
        .exception   (exception),
        .cause       (cause),
        .eret        (eret),
        .exc_pc      (exc_pc),
        .flush       (flush),
        .int_pending (int_pending)
    );

    always #5 clk = ~clk;

    // cycles_left counts the remaining cycles of an exception/return sequence
    typedef struct packed {
        logic [1:0]  cycles_left;
        logic        exc;
        logic        eret;
        logic        flush;
        logic [4:0]  cause;
        logic [31:0] pc;
        logic [3:0]  pend;
        logic [3:0]  prev;
    } m_t;

    m_t m;

    function automatic m_t model_next(m_t cur);
        m_t   n;
        logic ie;
        int   line;
        n    = cur;
        ie   = status[0];
        line = -1;
        n.exc  = 1'b0;
        n.eret = 1'b0;
        if (cur.cycles_left == 2) begin
            n.cycles_left = 1;
            n.flush       = 1'b1;
        end else if (cur.cycles_left == 1) begin
            n.cycles_left = 0;
            n.flush       = 1'b0;
            n.cause       = 5'd0;
            n.pc          = 32'd0;
        end else begin
            n.flush = 1'b0;
            n.cause = 5'd0;
            n.pc    = 32'd0;
`ifdef EXC_EXT_INT_EN
            if (!syscall && !brk && !teq_hit && !eret_in && ie)
                for (int i = 3; i >= 0; i--)
                    if (cur.pend[i] && status[8+i]) line = i;
`endif
            if (ie && syscall && status[1]) begin
                n = '{2'd2, 1'b1, 1'b0, 1'b1, 5'd8, pc, n.pend, n.prev};
            end else if (ie && brk && status[2]) begin
                n = '{2'd2, 1'b1, 1'b0, 1'b1, 5'd9, pc, n.pend, n.prev};
            end else if (ie && teq_hit && status[3]) begin
                n = '{2'd2, 1'b1, 1'b0, 1'b1, 5'd13, pc, n.pend, n.prev};
            end else if (eret_in) begin
                n = '{2'd2, 1'b0, 1'b1, 1'b1, 5'd0, 32'd0, n.pend, n.prev};
            end else if (line >= 0) begin
                n = '{2'd2, 1'b1, 1'b0, 1'b1, 5'd0, pc, n.pend, n.prev};
            end
        end
`ifdef EXC_EXT_INT_EN
        if (line >= 0) n.pend[line] = 1'b0;
        n.pend = n.pend | (ext_int & ~cur.prev);
        n.prev = ext_int;
`else
        n.pend = 4'd0;
        n.prev = 4'd0;
`endif
        if (rst) n = '0;
        return n;
    endfunction

    always @(posedge clk) m <= model_next(m);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_exception", {31'd0, exception}, {31'd0, m.exc});
            chk("m_eret", {31'd0, eret}, {31'd0, m.eret});
            chk("m_flush", {31'd0, flush}, {31'd0, m.flush});
            chk("m_cause", {27'd0, cause}, {27'd0, m.cause});
            chk("m_exc_pc", exc_pc, m.pc);
            chk("m_int_pending", {28'd0, int_pending}, {28'd0, m.pend});
            chk("m_exc_and_eret", {31'd0, exception & eret}, 32'd0);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        syscall = 0; brk = 0; teq_hit = 0; eret_in = 0;
    endtask

    initial begin
        rst = 1; idle_in(); pc = 0; status = 0; ext_int = 0;
        step(2);
        rst = 0;
        chk_en = 1'b1;
        chk("rst_exception", {31'd0, exception}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_cause", {27'd0, cause}, 32'd0);
        chk("rst_pending", {28'd0, int_pending}, 32'd0);
        step();

        status = 32'h0000_000F; pc = 32'h0040_0020; syscall = 1;
        step(); idle_in();
        chk("sys_exception", {31'd0, exception}, 32'd1);
        chk("sys_cause", {27'd0, cause}, 32'd8);
        chk("sys_exc_pc", exc_pc, 32'h0040_0020);
        chk("sys_flush", {31'd0, flush}, 32'd1);
        step();
        chk("sys_flush_exc", {31'd0, exception}, 32'd0);
        chk("sys_flush_flush", {31'd0, flush}, 32'd1);
        chk("sys_flush_pc", exc_pc, 32'h0040_0020);
        step();
        chk("sys_idle_flush", {31'd0, flush}, 32'd0);
        chk("sys_idle_cause", {27'd0, cause}, 32'd0);

        status = 32'h0000_0001; brk = 1;
        step(); idle_in();
        for (int i = 0; i < 3; i++) begin
            chk("brk_masked_exc", {31'd0, exception}, 32'd0);
            chk("brk_masked_flush", {31'd0, flush}, 32'd0);
            if (i < 2) step();
        end
        step();

        status = 32'h0000_000F; pc = 32'h0000_0100; syscall = 1; eret_in = 1;
        step(); idle_in();
        chk("sys_eret_exc", {31'd0, exception}, 32'd1);
        chk("sys_eret_cause", {27'd0, cause}, 32'd8);
        chk("sys_eret_eret", {31'd0, eret}, 32'd0);
        step(3);

        pc = 32'h0000_0200; teq_hit = 1;
        step();
        chk("teq_cause", {27'd0, cause}, 32'd13);
        idle_in(); step();
        teq_hit = 1;
        step(); idle_in();
        chk("teq_drop_exc", {31'd0, exception}, 32'd0);
        step();
        chk("teq_drop_exc2", {31'd0, exception}, 32'd0);

        status = 32'h0; eret_in = 1;
        step(); idle_in();
        chk("eret_eret", {31'd0, eret}, 32'd1);
        chk("eret_flush", {31'd0, flush}, 32'd1);
        step();
        chk("eret_flush_eret", {31'd0, eret}, 32'd0);
        step(2);

        status = 32'h0000_000F; pc = 32'h0000_0300; syscall = 1;
        step(); idle_in();
        chk("rst_mid_exc", {31'd0, exception}, 32'd1);
        rst = 1;
        step();
        rst = 0;
        chk("rst_mid_exception", {31'd0, exception}, 32'd0);
        chk("rst_mid_flush", {31'd0, flush}, 32'd0);
        chk("rst_mid_pc", exc_pc, 32'd0);
        step();
        chk("rst_after_exc", {31'd0, exception}, 32'd0);
        chk("rst_after_flush", {31'd0, flush}, 32'd0);
        step();

        status = 32'h0000_0301; pc = 32'h0000_2000; ext_int = 4'b0011;
        step();
`ifdef EXC_EXT_INT_EN
        chk("int_pend_set", {28'd0, int_pending}, 32'h3);
        step();
        chk("int0_exc", {31'd0, exception}, 32'd1);
        chk("int0_cause", {27'd0, cause}, 32'd0);
        chk("int0_pc", exc_pc, 32'h0000_2000);
        chk("int0_pend", {28'd0, int_pending}, 32'h2);
        step(3);
        chk("int1_exc", {31'd0, exception}, 32'd1);
        chk("int1_pend", {28'd0, int_pending}, 32'h0);
        step(3);
`else
        step(2);
        chk("noint_pend", {28'd0, int_pending}, 32'd0);
        chk("noint_exc", {31'd0, exception}, 32'd0);
`endif
        ext_int = 0;
        step(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
